register_file: RTL and testbench

Parametrised multi-entry register file generalising the single 32-bit enabled register: DEPTH words of WIDTH bits, one synchronous write port, and two combinational read ports.
- Serves as the architectural register bank of the processor datapath, feeding both ALU source operands in the same cycle.
- Optionally hardwires entry 0 to zero.
- Optionally forwards same-cycle write data to the read ports, so the pipeline sees a written value without waiting for the edge.

---
 rtl/register_file.sv | 46 ++++
 tb/tb_register_file.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register bank with one synchronous write port and two combinational read ports.
// Optional hardwired zero entry and optional same-cycle write-to-read forwarding.
module register_file #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned ADDR_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [ADDR_W-1:0] readAddrA,
    output logic [WIDTH-1:0]  readDataA,
    input  logic [ADDR_W-1:0] readAddrB,
    output logic [WIDTH-1:0]  readDataB
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;

    // Addresses are widened by one bit so DEPTH itself is representable for the range test.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = writeEnable && legal(writeAddr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[writeAddr] <= writeData;
        end
    end

    function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
        if (reset || !legal(a)) return '0;
        if ((BYPASS != 0) && wr_ok && (writeAddr == a)) return writeData;
        return mem_q[a];
    endfunction

    assign readDataA = rd(readAddrA);
    assign readDataB = rd(readAddrB);
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file across bypass, zero-register and non-power-of-two configurations.
module tb_register_file;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wa = '0, ra = '0, rb = '0;
    logic [31:0] wd = '0;
    logic [31:0] a0, b0, a1, b1, a2, b2;
    logic [15:0] a3, b3;
    int passed = 0;
    int total = 0;

    always #5 clock = ~clock;

    // u0: default (bypass, zero reg); u1: no bypass; u2: ordinary entry 0; u3: 24 x 16
    register_file u0 (.clock(clock), .reset(reset), .writeEnable(we), .writeAddr(wa), .writeData(wd),
                      .readAddrA(ra), .readDataA(a0), .readAddrB(rb), .readDataB(b0));
    register_file #(.BYPASS(0)) u1 (.clock(clock), .reset(reset), .writeEnable(we), .writeAddr(wa), .writeData(wd),
                      .readAddrA(ra), .readDataA(a1), .readAddrB(rb), .readDataB(b1));
    register_file #(.ZERO_REG(0)) u2 (.clock(clock), .reset(reset), .writeEnable(we), .writeAddr(wa), .writeData(wd),
                      .readAddrA(ra), .readDataA(a2), .readAddrB(rb), .readDataB(b2));
    register_file #(.WIDTH(16), .DEPTH(24)) u3 (.clock(clock), .reset(reset), .writeEnable(we), .writeAddr(wa),
                      .writeData(wd[15:0]), .readAddrA(ra), .readDataA(a3), .readAddrB(rb), .readDataB(b3));

    task automatic drive(input logic w, input logic [4:0] wadr, input logic [31:0] wdat,
                         input logic [4:0] radr_a, input logic [4:0] radr_b);
        we = w; wa = wadr; wd = wdat; ra = radr_a; rb = radr_b;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clock);
        drive(1'b1, 5'd3, 32'h0000_0ABC, 5'd3, 5'd3);
        total++; if (a0 !== 32'h0) $display("FAIL rst_fwd_a0 got %h want %h", a0, 32'h0); else passed++;
        total++; if (b2 !== 32'h0) $display("FAIL rst_fwd_b2 got %h want %h", b2, 32'h0); else passed++;
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        total++; if (a0 !== 32'h0) $display("FAIL rst_nowrite_a0 got %h want %h", a0, 32'h0); else passed++;
        total++; if (a2 !== 32'h0) $display("FAIL rst_nowrite_a2 got %h want %h", a2, 32'h0); else passed++;
    endtask

    task automatic test_reset_clear;
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            drive(1'b1, 5'(i), 32'hDEAD_BEEF, 5'd0, 5'd0);
        end
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        total++; if (a0 !== 32'hDEAD_BEEF) $display("FAIL fill_a0 got %h want %h", a0, 32'hDEAD_BEEF); else passed++;
        total++; if (b1 !== 32'hDEAD_BEEF) $display("FAIL fill_b1 got %h want %h", b1, 32'hDEAD_BEEF); else passed++;
        total++; if (b3 !== 16'h0) $display("FAIL fill_oob_b3 got %h want %h", b3, 16'h0); else passed++;
        reset = 1'b1;
        #1;
        total++; if (a0 !== 32'h0 || b0 !== 32'h0) $display("FAIL clr_now got %h/%h want 0/0", a0, b0); else passed++;
        reset = 1'b0;
        #1;
        total++; if (a1 !== 32'h0 || b2 !== 32'h0) $display("FAIL clr_after got %h/%h want 0/0", a1, b2); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1'b0, 5'd0, 32'h0, 5'(17 + i), 5'(2 + i));
            total++; if (a0 !== 32'h0 || b0 !== 32'h0) $display("FAIL clr_hold_u0 got %h/%h want 0/0", a0, b0); else passed++;
            total++; if (a3 !== 16'h0 || b3 !== 16'h0) $display("FAIL clr_hold_u3 got %h/%h want 0/0", a3, b3); else passed++;
        end
    endtask

    task automatic test_basic;
        @(negedge clock);
        drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd6);
        total++; if (a1 !== 32'h0) $display("FAIL basic_old_a1 got %h want %h", a1, 32'h0); else passed++;
        total++; if (a0 !== 32'h1234_5678) $display("FAIL basic_fwd_a0 got %h want %h", a0, 32'h1234_5678); else passed++;
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        total++; if (a1 !== 32'h1234_5678) $display("FAIL basic_new_a1 got %h want %h", a1, 32'h1234_5678); else passed++;
        total++; if (b1 !== 32'h0) $display("FAIL basic_b1 got %h want %h", b1, 32'h0); else passed++;
    endtask

    task automatic test_forward;
        @(negedge clock);
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
        total++; if (a0 !== 32'hA5A5_A5A5 || b0 !== 32'hA5A5_A5A5) $display("FAIL fwd_u0 got %h/%h want a5a5a5a5", a0, b0); else passed++;
        total++; if (a1 !== 32'h0 || b1 !== 32'h0) $display("FAIL fwd_nobyp_u1 got %h/%h want 0/0", a1, b1); else passed++;
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        total++; if (a0 !== 32'hA5A5_A5A5 || b1 !== 32'hA5A5_A5A5) $display("FAIL fwd_stored got %h/%h want a5a5a5a5", a0, b1); else passed++;
    endtask

    task automatic test_zero;
        @(negedge clock);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        total++; if (a0 !== 32'h0 || b0 !== 32'h0) $display("FAIL zero_during_u0 got %h/%h want 0/0", a0, b0); else passed++;
        total++; if (a2 !== 32'hFFFF_FFFF) $display("FAIL zero_fwd_u2 got %h want %h", a2, 32'hFFFF_FFFF); else passed++;
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        total++; if (a0 !== 32'h0 || b1 !== 32'h0) $display("FAIL zero_after got %h/%h want 0/0", a0, b1); else passed++;
        total++; if (b2 !== 32'hFFFF_FFFF) $display("FAIL zero_off_u2 got %h want %h", b2, 32'hFFFF_FFFF); else passed++;
    endtask

    task automatic test_npot;
        @(negedge clock);
        drive(1'b1, 5'd25, 32'h0000_BEEF, 5'd25, 5'd25);
        total++; if (a3 !== 16'h0) $display("FAIL npot_oob_fwd got %h want %h", a3, 16'h0); else passed++;
        @(negedge clock);
        drive(1'b1, 5'd23, 32'h0000_BEEF, 5'd25, 5'd23);
        total++; if (a3 !== 16'h0) $display("FAIL npot_oob_rd got %h want %h", a3, 16'h0); else passed++;
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd23, 5'd22);
        total++; if (a3 !== 16'hBEEF) $display("FAIL npot_23 got %h want %h", a3, 16'hBEEF); else passed++;
        total++; if (b3 !== 16'h0) $display("FAIL npot_22 got %h want %h", b3, 16'h0); else passed++;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        total++; if (a3 !== 16'h5678 || b3 !== 16'hA5A5) $display("FAIL npot_other got %h/%h want 5678/a5a5", a3, b3); else passed++;
    endtask

    task automatic test_reset_write;
        @(negedge clock);
        drive(1'b1, 5'd3, 32'h0F0F_0F0F, 5'd3, 5'd3);
        total++; if (a0 !== 32'h0F0F_0F0F) $display("FAIL rw_fwd got %h want %h", a0, 32'h0F0F_0F0F); else passed++;
        reset = 1'b1;
        #1;
        total++; if (a0 !== 32'h0 || b2 !== 32'h0) $display("FAIL rw_drop got %h/%h want 0/0", a0, b2); else passed++;
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        total++; if (a0 !== 32'h0 || a1 !== 32'h0) $display("FAIL rw_entry3 got %h/%h want 0/0", a0, a1); else passed++;
        total++; if (b2 !== 32'h0 || b3 !== 16'h0) $display("FAIL rw_entry3_b got %h/%h want 0/0", b2, b3); else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        drive(1'b1, 5'd9, 32'h1111_1111, 5'd9, 5'd9);
        total++; if (a0 !== 32'h1111_1111 || a1 !== 32'h0) $display("FAIL b2b_1 got %h/%h want 11111111/0", a0, a1); else passed++;
        @(negedge clock);
        drive(1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd9);
        total++; if (b0 !== 32'h2222_2222 || b1 !== 32'h1111_1111) $display("FAIL b2b_2 got %h/%h want 22222222/11111111", b0, b1); else passed++;
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        total++; if (a0 !== 32'h2222_2222 || a1 !== 32'h2222_2222) $display("FAIL b2b_last got %h/%h want 22222222", a0, a1); else passed++;
    endtask

    initial begin
        test_reset;
        test_reset_clear;
        test_basic;
        test_forward;
        test_zero;
        test_npot;
        test_reset_write;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
